wt_mem_req_issuer: RTL and testbench
====================================

Name: wt_mem_req_issuer

Overview:
- Initiator end of the write-through dcache memory interface.
- Accepts load/store commands from a bench agent and issues them as memory requests over the req/ack handshake.
- Allocates transaction IDs (tids), tracks outstanding transactions, and matches returns by tid.
- Delivers load/store completions back to the agent; counts invalidations and flags protocol errors. Drives a memory emulator directly in dcache-less benches.

Parameters:
- NumTids, 4, number of concurrently outstanding transactions (power of 2, 2..16); TidW = $clog2(NumTids).
- LineWidth, 128, cache line / return data width in bits (multiple of 64).
- TimeoutCycles, 1024, max cycles a tid may stay outstanding (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- cmd_valid_i  in  1  agent command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=store, 0=load.
- cmd_nc_i  in  1  noncached access.
- cmd_size_i  in  3  000 byte, 001 half, 010 word, 011 dword, 111 cache line.
- cmd_paddr_i  in  64  physical byte address.
- cmd_wdata_i  in  64  store data.
- mem_data_req_o  out  1  request valid.
- mem_data_ack_i  in  1  request taken.
- mem_data_we_o  out  1  0=LOAD_REQ, 1=STORE_REQ.
- mem_data_tid_o  out  TidW  transaction id.
- mem_data_nc_o  out  1  noncached.
- mem_data_size_o  out  3  size.
- mem_data_paddr_o  out  64  address.
- mem_data_data_o  out  64  store data.
- mem_rtrn_vld_i  in  1  return valid, one beat per cycle, no backpressure.
- mem_rtrn_type_i  in  2  00 LOAD_ACK, 01 STORE_ACK, 10 INV_REQ, 11 reserved.
- mem_rtrn_tid_i  in  TidW  return tid.
- mem_rtrn_data_i  in  LineWidth  load data.
- rsp_valid_o  out  1  completion pulse.
- rsp_we_o  out  1  completion type.
- rsp_tid_o  out  TidW  completed tid.
- rsp_data_o  out  LineWidth  load data; 0 for stores.
- inv_cnt_o  out  32  invalidation count, saturating.
- outstanding_o  out  TidW+1  popcount of busy tids.
- err_o  out  1  sticky protocol error.
- idle_o  out  1  no request pending and no tid busy.

Behaviour:
- Reset (async, rst_i=1): all outputs 0; busy vector cleared; FSM=IDLE; counters cleared. Reset mid-transaction drops the transaction silently, with no error.
- FSM states:
  - IDLE: cmd_ready_o = any tid free and not busy.
  - On cmd_valid_i & cmd_ready_o: register fields, assign lowest-index free tid, go to REQ.
  - REQ: mem_data_req_o=1; all mem_data_* held stable; on a sampled mem_data_ack_i, mark tid busy, record type, return to IDLE.
- Max issue rate: one request per 2 cycles. mem_data_req_o is never deasserted before ack.
- Cached load (we=0, nc=0): size forced to 111; paddr low $clog2(LineWidth/8) bits cleared.
- Store with size 111: command accepted, not issued, err_o set.
- Load/store ACK returns:
  - Error conditions (err_o set, return otherwise ignored): tid not busy; recorded type mismatches the ACK type; tid equals the tid being acked in the same cycle.
  - Otherwise: clear busy bit; next cycle rsp_valid_o=1 for one cycle with tid, type and data registered.
- INV_REQ: inv_cnt_o += 1, saturating at 0xFFFF_FFFF; tid ignored. Type 11 sets err_o.
- Simultaneous ack (set) and return (clear) of different tids: both take effect; outstanding_o is consistent the next cycle.
- All tids busy: cmd_ready_o=0 until a return frees one; the freed tid is allocatable the same cycle the busy bit clears (registered, so the cycle after the return).
- err_o clears only on reset.

Optional Feature:
- Macro: WT_MEM_REQ_TIMEOUT_EN.
- When defined: one counter per tid, cleared on allocation and incremented while busy. Reaching TimeoutCycles sets err_o and frees the tid; a later return for that tid is treated as unexpected (err_o).
- When undefined: no counters; tids may stay outstanding indefinitely.

Test Plan:
- Cached load 0x1004 size 011 -> issued size 111, paddr 0x1000, tid 0; LOAD_ACK tid 0 data D -> rsp_valid_o one cycle later, rsp_data_o=D, outstanding_o back to 0.
- Store 0x2008 data 0xDEADBEEF size 010, ack delayed 5 cycles -> req held 5 cycles with stable fields; STORE_ACK -> rsp_we_o=1, rsp_data_o=0.
- 5 loads back-to-back, memory silent -> tids 0..3 issued, cmd_ready_o=0 on 5th; ACK tid 2 -> 5th command gets tid 2.
- 3 INV_REQ returns interleaved with loads -> inv_cnt_o=3, loads complete normally, err_o=0.
- LOAD_ACK for tid 1 with nothing outstanding -> err_o=1 sticky; store size 111 -> err_o=1, no mem_data_req_o.
- rst_i asserted with 2 tids busy and req pending -> next cycle all outputs 0, idle_o=1 after release; with WT_MEM_REQ_TIMEOUT_EN and TimeoutCycles=16, unanswered load -> err_o at cycle 16.

Source files
------------

// File: rtl/wt_mem_req_issuer.sv
// wt_mem_req_issuer: initiator end of the write-through dcache memory interface.
// Accepts agent load/store commands, issues them over the req/ack handshake with
// a transaction id, tracks outstanding tids and matches returns by tid.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   cmd_*                  agent command (valid/ready, we, nc, size, paddr, wdata)
//   mem_data_*             memory request (req/ack, we, tid, nc, size, paddr, data)
//   mem_rtrn_*             memory return (vld, type, tid, data), no backpressure
//   rsp_*                  completion pulse to the agent (we, tid, data)
//   inv_cnt_o              saturating invalidation count
//   outstanding_o          number of busy tids
//   err_o                  sticky protocol error
//   idle_o                 no request pending and no tid busy
// Optional: define WT_MEM_REQ_TIMEOUT_EN to free tids outstanding for TimeoutCycles.
module wt_mem_req_issuer #(
  parameter int NumTids       = 4,
  parameter int LineWidth     = 128,
  parameter int TimeoutCycles = 1024,
  localparam int TidW         = $clog2(NumTids)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic                 cmd_nc_i,
  input  logic [2:0]           cmd_size_i,
  input  logic [63:0]          cmd_paddr_i,
  input  logic [63:0]          cmd_wdata_i,
  output logic                 mem_data_req_o,
  input  logic                 mem_data_ack_i,
  output logic                 mem_data_we_o,
  output logic [TidW-1:0]      mem_data_tid_o,
  output logic                 mem_data_nc_o,
  output logic [2:0]           mem_data_size_o,
  output logic [63:0]          mem_data_paddr_o,
  output logic [63:0]          mem_data_data_o,
  input  logic                 mem_rtrn_vld_i,
  input  logic [1:0]           mem_rtrn_type_i,
  input  logic [TidW-1:0]      mem_rtrn_tid_i,
  input  logic [LineWidth-1:0] mem_rtrn_data_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_we_o,
  output logic [TidW-1:0]      rsp_tid_o,
  output logic [LineWidth-1:0] rsp_data_o,
  output logic [31:0]          inv_cnt_o,
  output logic [TidW:0]        outstanding_o,
  output logic                 err_o,
  output logic                 idle_o
);
  typedef enum logic {IDLE, REQ} state_e;
  state_e              state;
  logic [NumTids-1:0]  busy, is_st, busy_set, busy_clr, tmo;
  logic [TidW-1:0]     free_tid;
  logic                accept, bad_st, cached_ld, acked, rtrn_ack, rtrn_ok, err_set;
  // ready/idle are held low while reset is asserted so every output reads 0
  assign cmd_ready_o    = !rst_i && state == IDLE && !(&busy);
  assign idle_o         = !rst_i && state == IDLE && !(|busy);
  assign mem_data_req_o = state == REQ;
  always_comb begin
    accept    = cmd_valid_i && cmd_ready_o;
    bad_st    = cmd_we_i && cmd_size_i == 3'b111;
    cached_ld = !cmd_we_i && !cmd_nc_i;
    acked     = state == REQ && mem_data_ack_i;
    rtrn_ack  = mem_rtrn_vld_i && !mem_rtrn_type_i[1];
    // a tid being acked this cycle is not yet busy, so a return for it is unexpected
    rtrn_ok   = rtrn_ack && busy[mem_rtrn_tid_i] && is_st[mem_rtrn_tid_i] == mem_rtrn_type_i[0]
                && !(acked && mem_rtrn_tid_i == mem_data_tid_o);
    busy_set  = acked ? NumTids'(1) << mem_data_tid_o : '0;
    busy_clr  = (rtrn_ok ? NumTids'(1) << mem_rtrn_tid_i : '0) | tmo;
    err_set   = (rtrn_ack && !rtrn_ok) || (mem_rtrn_vld_i && mem_rtrn_type_i == 2'b11)
                || (accept && bad_st) || |tmo;
    free_tid  = '0;
    for (int i = NumTids - 1; i >= 0; i--) if (!busy[i]) free_tid = TidW'(i);
    outstanding_o = '0;
    for (int i = 0; i < NumTids; i++) outstanding_o = outstanding_o + (TidW + 1)'(busy[i]);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      busy             <= '0;
      is_st            <= '0;
      mem_data_we_o    <= 1'b0;
      mem_data_tid_o   <= '0;
      mem_data_nc_o    <= 1'b0;
      mem_data_size_o  <= '0;
      mem_data_paddr_o <= '0;
      mem_data_data_o  <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_we_o         <= 1'b0;
      rsp_tid_o        <= '0;
      rsp_data_o       <= '0;
      inv_cnt_o        <= '0;
      err_o            <= 1'b0;
    end else begin
      busy        <= (busy & ~busy_clr) | busy_set;
      err_o       <= err_o | err_set;
      rsp_valid_o <= rtrn_ok;
      if (acked) is_st[mem_data_tid_o] <= mem_data_we_o;
      // a line-sized store is swallowed: flagged as an error, never issued
      if (accept && !bad_st) begin
        state            <= REQ;
        mem_data_we_o    <= cmd_we_i;
        mem_data_tid_o   <= free_tid;
        mem_data_nc_o    <= cmd_nc_i;
        mem_data_size_o  <= cached_ld ? 3'b111 : cmd_size_i;
        mem_data_paddr_o <= cached_ld ? cmd_paddr_i & ~64'(LineWidth / 8 - 1) : cmd_paddr_i;
        mem_data_data_o  <= cmd_wdata_i;
      end else if (acked) begin
        state <= IDLE;
      end
      if (rtrn_ok) begin
        rsp_we_o   <= mem_rtrn_type_i[0];
        rsp_tid_o  <= mem_rtrn_tid_i;
        rsp_data_o <= mem_rtrn_type_i[0] ? '0 : mem_rtrn_data_i;
      end
      if (mem_rtrn_vld_i && mem_rtrn_type_i == 2'b10 && !(&inv_cnt_o)) inv_cnt_o <= inv_cnt_o + 32'd1;
    end
  end
`ifdef WT_MEM_REQ_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  // per-tid age counter, restarted when the tid is handed out
  for (genvar i = 0; i < NumTids; i++) begin : g_tmo
    logic [CntW-1:0] cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt <= '0;
      else cnt <= busy_set[i] ? '0 : busy[i] ? cnt + 1'b1 : cnt;
    end
    assign tmo[i] = busy[i] && cnt == CntW'(TimeoutCycles - 1);
  end
`else
  assign tmo = '0;
`endif
endmodule

// File: tb/tb_wt_mem_req_issuer.sv
// tb_wt_mem_req_issuer: randomized self-checking bench for wt_mem_req_issuer
module tb_wt_mem_req_issuer;
  localparam int NT = 4;
  localparam int LW = 128;
  localparam int TW = $clog2(NT);
`ifdef WT_MEM_REQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  logic          clk = 0;
  logic          rst_i = 0;
  logic          cmd_valid_i = 0, cmd_ready_o, cmd_we_i = 0, cmd_nc_i = 0;
  logic [2:0]    cmd_size_i = 0;
  logic [63:0]   cmd_paddr_i = 0, cmd_wdata_i = 0;
  logic          mem_data_req_o, mem_data_ack_i = 0, mem_data_we_o, mem_data_nc_o;
  logic [TW-1:0] mem_data_tid_o;
  logic [2:0]    mem_data_size_o;
  logic [63:0]   mem_data_paddr_o, mem_data_data_o;
  logic          mem_rtrn_vld_i = 0;
  logic [1:0]    mem_rtrn_type_i = 0;
  logic [TW-1:0] mem_rtrn_tid_i = 0;
  logic [LW-1:0] mem_rtrn_data_i = 0;
  logic          rsp_valid_o, rsp_we_o, err_o, idle_o;
  logic [TW-1:0] rsp_tid_o;
  logic [LW-1:0] rsp_data_o;
  logic [31:0]   inv_cnt_o;
  logic [TW:0]   outstanding_o;
  int n_chk = 0, n_pass = 0;
  bit busy_m[int];
  logic [31:0] inv_m = 0;
  bit err_m = 0;

  wt_mem_req_issuer #(.NumTids(NT), .LineWidth(LW), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_nc_i(cmd_nc_i), .cmd_size_i(cmd_size_i), .cmd_paddr_i(cmd_paddr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .mem_data_req_o(mem_data_req_o), .mem_data_ack_i(mem_data_ack_i),
    .mem_data_we_o(mem_data_we_o), .mem_data_tid_o(mem_data_tid_o),
    .mem_data_nc_o(mem_data_nc_o), .mem_data_size_o(mem_data_size_o),
    .mem_data_paddr_o(mem_data_paddr_o), .mem_data_data_o(mem_data_data_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_type_i(mem_rtrn_type_i),
    .mem_rtrn_tid_i(mem_rtrn_tid_i), .mem_rtrn_data_i(mem_rtrn_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_tid_o(rsp_tid_o),
    .rsp_data_o(rsp_data_o), .inv_cnt_o(inv_cnt_o), .outstanding_o(outstanding_o),
    .err_o(err_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_free();
    for (int t = 0; t < NT; t++) if (!busy_m.exists(t)) return t;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit rtrn_expected_ok(input logic [1:0] ty, input int tid);
    return !ty[1] && busy_m.exists(tid) && busy_m[tid] == ty[0];
  endfunction

  task automatic drive_rtrn(input logic [1:0] ty, input int tid, input logic [127:0] d);
    mem_rtrn_vld_i = 1; mem_rtrn_type_i = ty; mem_rtrn_tid_i = TW'(tid); mem_rtrn_data_i = d;
  endtask

  // update the model for a return seen at the last edge and compare all visible effects
  task automatic post_rtrn(input bit present, input logic [1:0] ty, input int tid,
                           input logic [127:0] d, input bit ok);
    if (present) begin
      if (ty == 2'b10 && inv_m != 32'hFFFF_FFFF) inv_m++;
      if (ty == 2'b11 || (!ty[1] && !ok)) err_m = 1;
      if (ok) busy_m.delete(tid);
    end
    check("rsp_valid", rsp_valid_o, ok);
    if (ok) begin
      check("rsp_tid", rsp_tid_o, tid);
      check("rsp_we", rsp_we_o, ty[0]);
      check("rsp_data", rsp_data_o, ty[0] ? 128'd0 : d);
    end
    check("inv_cnt", inv_cnt_o, inv_m);
    check("err", err_o, err_m);
    check("outstanding", outstanding_o, busy_m.num());
    check("idle", idle_o, busy_m.num() == 0);
  endtask

  task automatic rtrn(input logic [1:0] ty, input int tid, input logic [127:0] d);
    bit ok;
    ok = rtrn_expected_ok(ty, tid);
    drive_rtrn(ty, tid, d);
    tick();
    mem_rtrn_vld_i = 0;
    post_rtrn(1, ty, tid, d, ok);
  endtask

  task automatic issue(input bit we, input bit nc, input logic [2:0] size, input logic [63:0] pa,
                       input logic [63:0] wd, input int dly, input bit do_ret,
                       input logic [1:0] rty, input int rtid, input logic [127:0] rd);
    int t;
    bit cached, ok;
    logic [2:0] esize;
    logic [63:0] epa;
    check("cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1; cmd_we_i = we; cmd_nc_i = nc; cmd_size_i = size;
    cmd_paddr_i = pa; cmd_wdata_i = wd;
    tick();
    cmd_valid_i = 0;
    if (we && size == 3'b111) begin
      err_m = 1;
      check("bad_store_req", mem_data_req_o, 0);
      check("bad_store_err", err_o, 1);
      return;
    end
    t = lowest_free();
    cached = !we && !nc;
    esize = cached ? 3'b111 : size;
    epa = cached ? pa & ~64'(LW / 8 - 1) : pa;
    check("req", mem_data_req_o, 1);
    check("req_tid", mem_data_tid_o, t);
    check("req_we", mem_data_we_o, we);
    check("req_nc", mem_data_nc_o, nc);
    check("req_size", mem_data_size_o, esize);
    check("req_paddr", mem_data_paddr_o, epa);
    check("req_data", mem_data_data_o, wd);
    check("ready_in_req", cmd_ready_o, 0);
    repeat (dly) begin
      tick();
      check("req_hold", mem_data_req_o, 1);
      check("hold_tid", mem_data_tid_o, t);
      check("hold_size", mem_data_size_o, esize);
      check("hold_paddr", mem_data_paddr_o, epa);
      check("hold_data", mem_data_data_o, wd);
    end
    mem_data_ack_i = 1;
    ok = 0;
    if (do_ret) begin
      ok = rtrn_expected_ok(rty, rtid);
      drive_rtrn(rty, rtid, rd);
    end
    tick();
    mem_data_ack_i = 0;
    mem_rtrn_vld_i = 0;
    busy_m[t] = we;
    check("req_drop", mem_data_req_o, 0);
    post_rtrn(do_ret, rty, rtid, rd, ok);
  endtask

  task automatic do_reset();
    rst_i = 1; cmd_valid_i = 0; mem_data_ack_i = 0; mem_rtrn_vld_i = 0;
    #2;
    check("rst_req", mem_data_req_o, 0);
    check("rst_ready", cmd_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_paddr", mem_data_paddr_o, 0);
    check("rst_inv", inv_cnt_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_err", err_o, 0);
    check("rst_idle", idle_o, 0);
    tick();
    tick();
    rst_i = 0;
    busy_m.delete(); inv_m = 0; err_m = 0;
    tick();
    check("idle_after_rst", idle_o, 1);
    check("ready_after_rst", cmd_ready_o, 1);
  endtask

  task automatic random_ops(input int n);
    for (int k = 0; k < n; k++) begin
      int r, q[$], pick;
      bit we, ret;
      r = $urandom_range(0, 9);
      q.delete();
      foreach (busy_m[j]) q.push_back(j);
      if (r < 5) begin
        if (busy_m.num() == NT) begin
          check("full_ready", cmd_ready_o, 0);
        end else begin
          we = 1'($urandom_range(0, 1));
          ret = q.size() > 0 && $urandom_range(0, 2) == 0;
          pick = q.size() > 0 ? q[$urandom_range(0, q.size() - 1)] : 0;
          issue(we, 1'($urandom_range(0, 1)), we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)),
                {$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom_range(0, 3),
                ret, ret && busy_m[pick] ? 2'b01 : 2'b00, pick, rnd128());
        end
      end else if (r < 9 && q.size() > 0) begin
        pick = q[$urandom_range(0, q.size() - 1)];
        rtrn(busy_m[pick] ? 2'b01 : 2'b00, pick, rnd128());
      end else begin
        rtrn(2'b10, $urandom_range(0, NT - 1), rnd128());
      end
    end
  endtask

  initial begin
    logic [127:0] d;
    #1;
    do_reset();
`ifdef WT_MEM_REQ_TIMEOUT_EN
    begin
      int n;
      issue(0, 0, 3'b011, 64'h1004, 64'h0, 0, 0, 2'b00, 0, 128'h0);
      n = 0;
      while (!err_o && n < 40) begin
        tick();
        n++;
      end
      check("tmo_cycles", n, TMO);
      check("tmo_freed", outstanding_o, 0);
      busy_m.delete();
      err_m = 1;
      rtrn(2'b00, 0, rnd128());
    end
`else
    d = rnd128();
    issue(0, 0, 3'b011, 64'h1004, 64'h55, 0, 0, 2'b00, 0, 128'h0);
    rtrn(2'b00, 0, d);
    issue(1, 0, 3'b010, 64'h2008, 64'hDEADBEEF, 5, 0, 2'b00, 0, 128'h0);
    rtrn(2'b01, 0, rnd128());
    for (int i = 0; i < 4; i++) issue(0, 0, 3'b011, 64'h3000 + 64'(i * 16), 64'h0, 0, 0, 2'b00, 0, 128'h0);
    cmd_valid_i = 1; cmd_we_i = 0; cmd_nc_i = 0; cmd_size_i = 3'b011; cmd_paddr_i = 64'h4000;
    check("full_ready", cmd_ready_o, 0);
    repeat (3) begin
      tick();
      check("full_ready_hold", cmd_ready_o, 0);
      check("full_no_req", mem_data_req_o, 0);
    end
    cmd_valid_i = 0;
    rtrn(2'b00, 2, rnd128());
    issue(0, 0, 3'b011, 64'h4000, 64'h0, 0, 0, 2'b00, 0, 128'h0);
    check("tid2_reused", mem_data_tid_o, 2);
    for (int i = 0; i < 4; i++) rtrn(2'b00, i, rnd128());
    rtrn(2'b10, 3, rnd128());
    issue(0, 1, 3'b001, 64'h5002, 64'h0, 1, 0, 2'b00, 0, 128'h0);
    rtrn(2'b10, 0, rnd128());
    rtrn(2'b00, 0, rnd128());
    rtrn(2'b10, 1, rnd128());
    check("inv_three", inv_cnt_o, 3);
    check("inv_no_err", err_o, 0);
    random_ops(250);
    issue(0, 0, 3'b000, 64'h10, 64'h0, 0, 0, 2'b00, 0, 128'h0);
    do_reset();
    issue(0, 0, 3'b000, 64'h100, 64'h0, 0, 0, 2'b00, 0, 128'h0);
    issue(1, 1, 3'b011, 64'h200, 64'h1, 0, 0, 2'b00, 0, 128'h0);
    cmd_valid_i = 1; cmd_we_i = 0; cmd_nc_i = 0; cmd_size_i = 0; cmd_paddr_i = 64'h300;
    tick();
    cmd_valid_i = 0;
    check("mid_req", mem_data_req_o, 1);
    check("mid_outstanding", outstanding_o, 2);
    do_reset();
    rtrn(2'b00, 1, rnd128());
    repeat (3) tick();
    check("err_sticky", err_o, 1);
    do_reset();
    issue(1, 0, 3'b111, 64'h40, 64'h1, 0, 0, 2'b00, 0, 128'h0);
    tick();
    check("bad_store_no_req", mem_data_req_o, 0);
    do_reset();
    issue(0, 0, 3'b010, 64'h80, 64'h0, 0, 1, 2'b00, 0, rnd128());
    do_reset();
    issue(0, 0, 3'b010, 64'h80, 64'h0, 0, 0, 2'b00, 0, 128'h0);
    rtrn(2'b01, 0, rnd128());
    do_reset();
    rtrn(2'b11, 0, rnd128());
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
